// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack CPU: opcode field width, opcode values and FSM states.
// Kept in one package so the core and the ALU decode opcodes identically.
package stack_cpu_pkg;

    localparam int unsigned OP_W = 32'd6;

    localparam logic [OP_W-1:0] OP_PUSHI = 6'h01;
    localparam logic [OP_W-1:0] OP_ADD   = 6'h02;
    localparam logic [OP_W-1:0] OP_SUB   = 6'h03;
    localparam logic [OP_W-1:0] OP_AND   = 6'h04;
    localparam logic [OP_W-1:0] OP_OR    = 6'h05;
    localparam logic [OP_W-1:0] OP_XOR   = 6'h06;
    localparam logic [OP_W-1:0] OP_JMP   = 6'h08;
    localparam logic [OP_W-1:0] OP_JZ    = 6'h09;
    localparam logic [OP_W-1:0] OP_HALT  = 6'h3F;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_POP1   = 3'd2,
        ST_POP2   = 3'd3,
        ST_PUSH   = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    function automatic logic is_alu_op(input logic [OP_W-1:0] op);
        logic hit_s;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: hit_s = 1'b1;
            default:                               hit_s = 1'b0;
        endcase
        return hit_s;
    endfunction

endpackage

// File: rtl/stack_cpu_alu.sv
// Combinational two-operand ALU; result = a op b, wrapping at DATA_W bits.
module stack_cpu_alu
    import stack_cpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32'd16
) (
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    // Opcode-selected arithmetic/logic operation; non-ALU opcodes yield zero.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/stack_cpu_core.sv
// Multi-cycle stack CPU with a single-outstanding request/ack memory port.
// The stack grows downward in memory; PUSH writes mem[SP-1], POP reads mem[SP].
module stack_cpu_core
    import stack_cpu_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32'd16,
    parameter int unsigned       ADDR_W      = 32'd16,
    parameter logic [ADDR_W-1:0] ENTRY_POINT = ADDR_W'(16'h0020),
    parameter logic [ADDR_W-1:0] STACK_START = ADDR_W'(16'hFFFF),
    parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(16'hFF00)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              error,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] sp
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] sp_r;
    logic [DATA_W-1:0] r1_r;
    logic [DATA_W-1:0] r2_r;
    logic [DATA_W-1:0] ir_r;
    logic              halted_r;
    logic              error_r;

    logic [OP_W-1:0]   opcode_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] alu_res_s;
    logic [DATA_W-1:0] push_data_s;
    logic              underflow_s;
    logic              overflow_s;
    logic              xfer_s;

    assign opcode_s    = ir_r[DATA_W-1 -: OP_W];
    assign imm_s       = DATA_W'(ir_r[DATA_W-OP_W-1:0]);
    assign push_data_s = (opcode_s == OP_PUSHI) ? imm_s : alu_res_s;
    assign underflow_s = (sp_r == STACK_START);
    assign overflow_s  = (sp_r == STACK_LIMIT);
    assign xfer_s      = mem_req & mem_ack;

    assign pc     = pc_r;
    assign sp     = sp_r;
    assign halted = halted_r;
    assign error  = error_r;

    stack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opcode_s),
        .a      (r2_r),
        .b      (r1_r),
        .result (alu_res_s)
    );

    // Memory port decoded from registered state only, so it stays put across wait cycles;
    // gated by rst_n so a reset drops the request immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_n) begin
            case (state_r)
                ST_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_r;
                end
                ST_POP1, ST_POP2: begin
                    mem_req  = ~underflow_s;
                    mem_addr = sp_r;
                end
                ST_PUSH: begin
                    mem_req   = ~overflow_s;
                    mem_we    = ~overflow_s;
                    mem_addr  = sp_r - ADDR_ONE;
                    mem_wdata = push_data_s;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    // Instruction sequencer: every state waits for its transfer, then advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_FETCH;
            pc_r     <= ENTRY_POINT;
            sp_r     <= STACK_START;
            r1_r     <= '0;
            r2_r     <= '0;
            ir_r     <= '0;
            halted_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (xfer_s) begin
                        ir_r    <= mem_rdata;
                        pc_r    <= pc_r + ADDR_ONE;
                        state_r <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (opcode_s == OP_PUSHI) begin
                        state_r <= ST_PUSH;
                    end else if (is_alu_op(opcode_s) || (opcode_s == OP_JMP) || (opcode_s == OP_JZ)) begin
                        state_r <= ST_POP1;
                    end else if (opcode_s == OP_HALT) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end
                end
                ST_POP1: begin
                    if (underflow_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (xfer_s) begin
                        r1_r <= mem_rdata;
                        sp_r <= sp_r + ADDR_ONE;
                        if (opcode_s == OP_JMP) begin
                            pc_r    <= ADDR_W'(mem_rdata);
                            state_r <= ST_FETCH;
                        end else begin
                            state_r <= ST_POP2;
                        end
                    end
                end
                ST_POP2: begin
                    if (underflow_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (xfer_s) begin
                        r2_r <= mem_rdata;
                        sp_r <= sp_r + ADDR_ONE;
                        if (opcode_s == OP_JZ) begin
                            // Branch target already sits in R1; the condition is the word just read.
                            if (mem_rdata == '0) begin
                                pc_r <= ADDR_W'(r1_r);
                            end
                            state_r <= ST_FETCH;
                        end else begin
                            state_r <= ST_PUSH;
                        end
                    end
                end
                ST_PUSH: begin
                    if (overflow_s) begin
                        state_r <= ST_ERROR;
                        error_r <= 1'b1;
                    end else if (xfer_s) begin
                        sp_r    <= sp_r - ADDR_ONE;
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    state_r <= ST_ERROR;
                    error_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_cpu_core.sv
// Self-checking bench for stack_cpu_core: directed vector table, reset/overflow corner
// sequences, and random programs compared with an instruction-level reference interpreter.
module tb_stack_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        halted, error;
    logic [15:0] pc, sp;

    always #5 clk = ~clk;

    stack_cpu_core dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted), .error(error), .pc(pc), .sp(sp)
    );

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic [15:0] rprog   [0:31];

    int          checks = 0;
    int          errors = 0;
    int          cycles, writes, stall_left;
    bit          in_xfer;
    logic [15:0] last_fetch, hold_addr, hold_wdata;
    logic        hold_we;

    typedef struct {
        logic [15:0] p0, p1, p2, p3;
        logic [15:0] jaddr, jword;
        logic        exp_halt, exp_err;
        logic [15:0] exp_sp, exp_addr, exp_data, exp_fetch;
        int          exp_cyc, exp_writes;
    } vec_t;

    vec_t vecs [0:10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] w);
        mem[a]     = w;
        ref_mem[a] = w;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        in_xfer    = 1'b0;
        stall_left = 0;
        cycles     = 0;
        writes     = 0;
        last_fetch = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock: drive ack/rdata on the falling edge, commit the completed transfer after the rising edge.
    task automatic step(input int max_stall);
        bit          fire;
        logic        w;
        logic [15:0] a, d;
        @(negedge clk);
        if (mem_req) begin
            if (!in_xfer) begin
                in_xfer    = 1'b1;
                stall_left = $urandom_range(max_stall, 0);
                hold_addr  = mem_addr;
                hold_we    = mem_we;
                hold_wdata = mem_wdata;
            end else begin
                check("hold_addr", mem_addr, hold_addr);
                check("hold_we", mem_we, hold_we);
                check("hold_wdata", mem_wdata, hold_wdata);
            end
        end else begin
            in_xfer    = 1'b0;
            stall_left = 0;
        end
        mem_ack = (stall_left == 0);
        if (!mem_ack) stall_left--;
        mem_rdata = mem[mem_addr];
        fire = mem_req && mem_ack;
        a = mem_addr;
        w = mem_we;
        d = mem_wdata;
        @(posedge clk);
        #1;
        cycles++;
        if (fire) begin
            in_xfer = 1'b0;
            if (w) begin
                mem[a] = d;
                writes++;
            end else if (a < 16'hFF00) begin
                last_fetch = a;
            end
        end
    endtask

    task automatic run_prog(input int max_stall, input int budget);
        int n = 0;
        while (!(halted === 1'b1 || error === 1'b1) && n < budget) begin
            step(max_stall);
            n++;
        end
        check("run_terminates", halted | error, 1);
    endtask

    // Instruction-level interpreter of the ISA on ref_mem; cycle cost per instruction from the latency table.
    task automatic model(output logic [15:0] m_sp, output bit m_halt, output bit m_err,
                         output int m_cyc, output logic [15:0] m_fetch);
        logic [15:0] p, s, instr, a, b, r;
        logic [5:0]  op;
        p = 16'h0020; s = 16'hFFFF; m_halt = 1'b0; m_err = 1'b0; m_cyc = 0; m_fetch = 16'h0000;
        for (int n = 0; n < 4000 && !m_halt && !m_err; n++) begin
            instr   = ref_mem[p];
            m_fetch = p;
            p       = p + 16'd1;
            op      = instr[15:10];
            case (op)
                6'h01: begin
                    if (s == 16'hFF00) m_err = 1'b1;
                    else begin s = s - 16'd1; ref_mem[s] = {6'd0, instr[9:0]}; m_cyc += 3; end
                end
                6'h02, 6'h03, 6'h04, 6'h05, 6'h06: begin
                    if (s == 16'hFFFF) m_err = 1'b1;
                    else begin
                        b = ref_mem[s]; s = s + 16'd1;
                        if (s == 16'hFFFF) m_err = 1'b1;
                        else begin
                            a = ref_mem[s]; s = s + 16'd1;
                            case (op)
                                6'h02:   r = a + b;
                                6'h03:   r = a - b;
                                6'h04:   r = a & b;
                                6'h05:   r = a | b;
                                default: r = a ^ b;
                            endcase
                            s = s - 16'd1; ref_mem[s] = r; m_cyc += 5;
                        end
                    end
                end
                6'h08: begin
                    if (s == 16'hFFFF) m_err = 1'b1;
                    else begin p = ref_mem[s]; s = s + 16'd1; m_cyc += 3; end
                end
                6'h09: begin
                    if (s == 16'hFFFF) m_err = 1'b1;
                    else begin
                        b = ref_mem[s]; s = s + 16'd1;
                        if (s == 16'hFFFF) m_err = 1'b1;
                        else begin
                            a = ref_mem[s]; s = s + 16'd1;
                            if (a == 16'h0000) p = b;
                            m_cyc += 4;
                        end
                    end
                end
                6'h3F: begin m_halt = 1'b1; m_cyc += 2; end
                default: m_err = 1'b1;
            endcase
        end
        m_sp = s;
    endtask

    task automatic run_and_compare(input string tag, input int max_stall);
        logic [15:0] m_sp, m_fetch;
        bit          m_halt, m_err;
        int          m_cyc, bad;
        do_reset();
        run_prog(max_stall, 4000);
        model(m_sp, m_halt, m_err, m_cyc, m_fetch);
        bad = 0;
        for (int a = 16'hFF00; a <= 16'hFFFF; a++) if (mem[a] !== ref_mem[a]) bad++;
        check({tag, "_sp"}, sp, m_sp);
        check({tag, "_halted"}, halted, m_halt);
        check({tag, "_error"}, error, m_err);
        check({tag, "_fetch"}, last_fetch, m_fetch);
        check({tag, "_stack"}, bad, 0);
        if (max_stall == 0 && m_halt) check({tag, "_cycles"}, cycles, m_cyc);
    endtask

    task automatic gen_random(output int len);
        int depth = 0;
        len = $urandom_range(20, 6);
        for (int i = 0; i < len; i++) begin
            if (depth < 2 || $urandom_range(1, 0) == 0) begin
                rprog[i] = {6'h01, 10'($urandom)};
                depth++;
            end else begin
                rprog[i] = {6'(2 + $urandom_range(4, 0)), 10'($urandom)};
                depth--;
            end
        end
        if ($urandom_range(3, 0) == 0) rprog[len] = {6'($urandom_range(62, 10)), 10'h000};
        else                           rprog[len] = 16'hFC00;
        len++;
    endtask

    initial begin
        int          len, n;
        logic [15:0] m_sp, m_fetch;
        bit          m_halt, m_err;
        int          m_cyc;

        //          p0       p1       p2       p3       jaddr    jword    h     e     sp        addr      data      fetch     cyc  wr
        vecs[0]  = '{16'h0405, 16'h0403, 16'h0800, 16'hFC00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 16'h0008, 16'h0023, 13, 3};
        vecs[1]  = '{16'h0402, 16'h0407, 16'h0C00, 16'hFC00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 16'hFFFB, 16'h0023, 13, 3};
        vecs[2]  = '{16'h04F0, 16'h07CC, 16'h1000, 16'hFC00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 16'h00C0, 16'h0023, 13, 3};
        vecs[3]  = '{16'h04F0, 16'h07CC, 16'h1400, 16'hFC00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 16'h03FC, 16'h0023, 13, 3};
        vecs[4]  = '{16'h04F0, 16'h07CC, 16'h1800, 16'hFC00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 16'h033C, 16'h0023, 13, 3};
        vecs[5]  = '{16'h0400, 16'h0440, 16'h2400, 16'h4000, 16'h0040, 16'hFC00, 1'b1, 1'b0, 16'hFFFF, 16'hFFFD, 16'h0040, 16'h0040, 12, 2};
        vecs[6]  = '{16'h0401, 16'h0440, 16'h2400, 16'hFC00, 16'h0040, 16'h4000, 1'b1, 1'b0, 16'hFFFF, 16'hFFFE, 16'h0001, 16'h0023, 12, 2};
        vecs[7]  = '{16'h0450, 16'h2000, 16'h4000, 16'h0000, 16'h0050, 16'hFC00, 1'b1, 1'b0, 16'hFFFF, 16'hFFFE, 16'h0050, 16'h0050,  8, 1};
        vecs[8]  = '{16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0020,  0, 0};
        vecs[9]  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0000, 16'h0020,  0, 0};
        vecs[10] = '{16'h0409, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'hFFFF, 16'hFFFE, 16'h0009, 16'h0021,  0, 1};

        // Reset values while rst_n is held low.
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'h0000;
        clear_mem();
        repeat (2) @(posedge clk);
        #2;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_pc", pc, 16'h0020);
        check("rst_sp", sp, 16'hFFFF);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);

        // First request after release must already be a fetch of the entry point.
        do_reset();
        #1;
        check("first_req", mem_req, 1);
        check("first_we", mem_we, 0);
        check("first_addr", mem_addr, 16'h0020);

        for (int i = 0; i < 11; i++) begin
            clear_mem();
            put(16'h0020, vecs[i].p0); put(16'h0021, vecs[i].p1);
            put(16'h0022, vecs[i].p2); put(16'h0023, vecs[i].p3);
            put(vecs[i].jaddr, vecs[i].jword);
            do_reset();
            run_prog(0, 200);
            check($sformatf("v%0d_sp", i), sp, vecs[i].exp_sp);
            check($sformatf("v%0d_halted", i), halted, vecs[i].exp_halt);
            check($sformatf("v%0d_error", i), error, vecs[i].exp_err);
            check($sformatf("v%0d_mem", i), mem[vecs[i].exp_addr], vecs[i].exp_data);
            check($sformatf("v%0d_fetch", i), last_fetch, vecs[i].exp_fetch);
            check($sformatf("v%0d_writes", i), writes, vecs[i].exp_writes);
            if (vecs[i].exp_halt) check($sformatf("v%0d_cycles", i), cycles, vecs[i].exp_cyc);
            repeat (3) step(0);
            check($sformatf("v%0d_sticky_h", i), halted, vecs[i].exp_halt);
            check($sformatf("v%0d_sticky_e", i), error, vecs[i].exp_err);
            check($sformatf("v%0d_idle_req", i), mem_req, 0);
        end

        // Overflow: 256 pushes from an empty stack, the last one hits the limit.
        clear_mem();
        for (int i = 0; i < 256; i++) put(16'(16'h0020 + i), 16'h0401);
        do_reset();
        run_prog(1, 3000);
        check("ovf_error", error, 1);
        check("ovf_sp", sp, 16'hFF00);
        check("ovf_writes", writes, 255);
        model(m_sp, m_halt, m_err, m_cyc, m_fetch);
        check("ovf_model_sp", sp, m_sp);

        // Reset pulse during a stalled push.
        clear_mem();
        put(16'h0020, 16'h0405); put(16'h0021, 16'h0403); put(16'h0022, 16'h0800); put(16'h0023, 16'hFC00);
        do_reset();
        n = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 50) begin step(0); n++; end
        check("r_in_push", mem_req & mem_we, 1);
        @(negedge clk); mem_ack = 1'b0;
        @(posedge clk); #1;
        check("r_stall_we", mem_we, 1);
        check("r_stall_addr", mem_addr, 16'hFFFE);
        @(negedge clk); #1;
        rst_n = 1'b0; mem_ack = 1'b1;
        #1;
        check("r_req_drop", mem_req, 0);
        check("r_sp", sp, 16'hFFFF);
        @(posedge clk); #1;
        check("r_sp_hold", sp, 16'hFFFF);
        check("r_no_write", mem[16'hFFFE], 16'h0000);
        @(negedge clk); #1;
        mem_ack = 1'b0; rst_n = 1'b1; in_xfer = 1'b0; stall_left = 0;
        #1;
        check("r_next_req", mem_req, 1);
        check("r_next_we", mem_we, 0);
        check("r_next_addr", mem_addr, 16'h0020);
        run_prog(2, 500);
        check("r_rerun_mem", mem[16'hFFFE], 16'h0008);

        // Random programs, each run with zero-wait and stalled memory.
        for (int r = 0; r < 12; r++) begin
            gen_random(len);
            for (int pass = 0; pass < 2; pass++) begin
                clear_mem();
                for (int i = 0; i < len; i++) put(16'(16'h0020 + i), rprog[i]);
                run_and_compare($sformatf("rnd%0d_s%0d", r, pass * 3), pass * 3);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
